// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control definitions: opcodes, func codes, control bus encodings and sequencer states.
// Build option CTRL_BRANCH_EN adds the EXEC_BR state for beq/bne.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [5:0] FUNC_ADD = 6'b100000;
    localparam logic [5:0] FUNC_SUB = 6'b100010;
    localparam logic [5:0] FUNC_AND = 6'b100100;
    localparam logic [5:0] FUNC_OR  = 6'b100101;
    localparam logic [5:0] FUNC_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    // Bit positions inside muxctrl
    localparam int MX_PC_BR      = 0;
    localparam int MX_ALU_A      = 1;
    localparam int MX_ALU_B_LO   = 2;
    localparam int MX_REG_DST    = 4;
    localparam int MX_MEM_TO_REG = 5;
    localparam int MX_IORD       = 6;

    localparam logic [1:0] ALUB_RT   = 2'b00;
    localparam logic [1:0] ALUB_FOUR = 2'b01;
    localparam logic [1:0] ALUB_IMM  = 2'b10;

    localparam logic [1:0] MEM_IDLE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    typedef enum logic [3:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC_R,
        ST_WB_R,
        ST_EXEC_I,
        ST_WB_I,
        ST_MEM,
        ST_WB_MEM,
`ifdef CTRL_BRANCH_EN
        ST_EXEC_BR,
`endif
        ST_FAULT
    } state_t;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mc_sequencer_if.sv
// Control bundle between the multi-cycle sequencer (master) and the datapath/IR/memory side (slave).
interface mc_sequencer_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       op;
    logic [5:0]       func;
    logic             zero;
    logic             mem_ready;
    logic [6:0]       muxctrl;
    logic [1:0]       memctrl;
    logic [2:0]       aluctrl;
    logic             pc_we;
    logic             ir_we;
    logic             reg_we;
    logic             fault;
    logic [CNT_W-1:0] retired;

    modport master (
        input  op, func, zero, mem_ready,
        output muxctrl, memctrl, aluctrl, pc_we, ir_we, reg_we, fault, retired
    );

    modport slave (
        output op, func, zero, mem_ready,
        input  muxctrl, memctrl, aluctrl, pc_we, ir_we, reg_we, fault, retired
    );
endinterface

// File: rtl/mc_alu_decode.sv
// R-type func field to ALU operation decode; valid=0 for functions the datapath does not support.
module mc_alu_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] func,
    output logic [2:0] aluctrl,
    output logic       valid
);

    always_comb begin
        aluctrl = ALU_ADD;
        valid   = 1'b1;
        case (func)
            FUNC_ADD: aluctrl = ALU_ADD;
            FUNC_SUB: aluctrl = ALU_SUB;
            FUNC_AND: aluctrl = ALU_AND;
            FUNC_OR:  aluctrl = ALU_OR;
            FUNC_SLT: aluctrl = ALU_SLT;
            default:  valid   = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB with memory-ready timeout and sticky fault.
// Build option CTRL_BRANCH_EN enables beq/bne through EXEC_BR; otherwise they decode as illegal.
module mc_sequencer
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic          clk,
    input  logic          reset,
    mc_sequencer_if.master bus
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            state_reg, state_next;
    logic [WAIT_W-1:0] wait_reg, wait_next;
    logic [CNT_W-1:0]  retired_reg, retired_next;
    logic [5:0]        op_reg;
    logic [2:0]        alu_sel_reg;

    logic [2:0] dec_aluctrl;
    logic       dec_valid;
    logic       timeout;
    logic       retire;

    logic [6:0] mux_sel;
    logic [1:0] mem_sel;
    logic [2:0] alu_sel;
    logic       pc_we_sel, ir_we_sel, reg_we_sel, fault_sel;

    mc_alu_decode u_alu_decode (
        .func    (bus.func),
        .aluctrl (dec_aluctrl),
        .valid   (dec_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_FETCH;
            wait_reg    <= '0;
            retired_reg <= '0;
            op_reg      <= '0;
            alu_sel_reg <= ALU_ADD;
        end else begin
            state_reg   <= state_next;
            wait_reg    <= wait_next;
            retired_reg <= retired_next;
            if (state_reg == ST_DECODE) begin
                op_reg      <= bus.op;
                alu_sel_reg <= dec_aluctrl;
            end
        end
    end

    // mem_ready in the final wait cycle wins over the timeout
    assign timeout = !bus.mem_ready && (wait_reg == WAIT_W'(MEM_TIMEOUT - 1));

    always_comb begin
        state_next = state_reg;
        mux_sel    = '0;
        mem_sel    = MEM_IDLE;
        alu_sel    = ALU_ADD;
        pc_we_sel  = 1'b0;
        ir_we_sel  = 1'b0;
        reg_we_sel = 1'b0;
        fault_sel  = 1'b0;
        retire     = 1'b0;
        case (state_reg)
            ST_FETCH: begin
                mem_sel                   = MEM_READ;
                mux_sel[MX_ALU_B_LO +: 2] = ALUB_FOUR;
                if (bus.mem_ready) begin
                    ir_we_sel  = 1'b1;
                    pc_we_sel  = 1'b1;
                    state_next = ST_DECODE;
                end else if (timeout) begin
                    state_next = ST_FAULT;
                end
            end
            ST_DECODE: begin
                mux_sel[MX_ALU_B_LO +: 2] = ALUB_IMM;
                case (bus.op)
                    OP_RTYPE:               state_next = dec_valid ? ST_EXEC_R : ST_FAULT;
                    OP_LW, OP_SW, OP_ADDI:  state_next = ST_EXEC_I;
`ifdef CTRL_BRANCH_EN
                    OP_BEQ, OP_BNE:         state_next = ST_EXEC_BR;
`endif
                    default:                state_next = ST_FAULT;
                endcase
            end
            ST_EXEC_R: begin
                mux_sel[MX_ALU_A]         = 1'b1;
                mux_sel[MX_ALU_B_LO +: 2] = ALUB_RT;
                alu_sel                   = alu_sel_reg;
                state_next                = ST_WB_R;
            end
            ST_WB_R: begin
                reg_we_sel          = 1'b1;
                mux_sel[MX_REG_DST] = 1'b1;
                retire              = 1'b1;
                state_next          = ST_FETCH;
            end
            ST_EXEC_I: begin
                mux_sel[MX_ALU_A]         = 1'b1;
                mux_sel[MX_ALU_B_LO +: 2] = ALUB_IMM;
                state_next                = is_mem_op(op_reg) ? ST_MEM : ST_WB_I;
            end
            ST_WB_I: begin
                reg_we_sel = 1'b1;
                retire     = 1'b1;
                state_next = ST_FETCH;
            end
            ST_MEM: begin
                mux_sel[MX_IORD] = 1'b1;
                mem_sel          = (op_reg == OP_SW) ? MEM_WRITE : MEM_READ;
                if (bus.mem_ready) begin
                    if (op_reg == OP_SW) begin
                        retire     = 1'b1;
                        state_next = ST_FETCH;
                    end else begin
                        state_next = ST_WB_MEM;
                    end
                end else if (timeout) begin
                    state_next = ST_FAULT;
                end
            end
            ST_WB_MEM: begin
                reg_we_sel             = 1'b1;
                mux_sel[MX_MEM_TO_REG] = 1'b1;
                retire                 = 1'b1;
                state_next             = ST_FETCH;
            end
`ifdef CTRL_BRANCH_EN
            ST_EXEC_BR: begin
                mux_sel[MX_ALU_A]         = 1'b1;
                mux_sel[MX_ALU_B_LO +: 2] = ALUB_RT;
                alu_sel                   = ALU_SUB;
                pc_we_sel  = ((op_reg == OP_BEQ) && bus.zero) || ((op_reg == OP_BNE) && !bus.zero);
                mux_sel[MX_PC_BR]         = pc_we_sel;
                retire                    = 1'b1;
                state_next                = ST_FETCH;
            end
`endif
            ST_FAULT: begin
                fault_sel = 1'b1;
            end
            default: begin
                state_next = ST_FAULT;
            end
        endcase
    end

`ifdef CTRL_BRANCH_EN
`else
    logic unused_zero;
    assign unused_zero = bus.zero;
`endif

    // The wait counter only runs while parked in FETCH or MEM; any state change restarts it
    always_comb begin
        wait_next = '0;
        if ((state_reg == ST_FETCH || state_reg == ST_MEM) && (state_next == state_reg)) begin
            wait_next = wait_reg + WAIT_W'(1);
        end
    end

    assign retired_next = retired_reg + CNT_W'(retire);

    assign bus.muxctrl = reset ? '0 : mux_sel;
    assign bus.memctrl = reset ? '0 : mem_sel;
    assign bus.aluctrl = reset ? '0 : alu_sel;
    assign bus.pc_we   = !reset && pc_we_sel;
    assign bus.ir_we   = !reset && ir_we_sel;
    assign bus.reg_we  = !reset && reg_we_sel;
    assign bus.fault   = !reset && fault_sel;
    assign bus.retired = (reset || state_reg == ST_FAULT) ? '0 : retired_reg;

endmodule

// File: tb/tb_mc_sequencer.sv
// Scoreboard bench for mc_sequencer: per-cycle expected control vectors are queued with their stimulus.
module tb_mc_sequencer;
    import mips_ctrl_pkg::*;

    localparam int CNT_W = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mc_sequencer_if #(.CNT_W(CNT_W)) bus ();

    mc_sequencer #(.MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // {fault, reg_we, ir_we, pc_we, aluctrl[2:0], memctrl[1:0], muxctrl[6:0]}
    localparam logic [15:0] E_ZERO  = 16'h0000;
    localparam logic [15:0] E_FETCH = {4'b0011, 3'b000, 2'b01, 7'b0000100};
    localparam logic [15:0] E_FWAIT = {4'b0000, 3'b000, 2'b01, 7'b0000100};
    localparam logic [15:0] E_DEC   = {4'b0000, 3'b000, 2'b00, 7'b0001000};
    localparam logic [15:0] E_WBR   = {4'b0100, 3'b000, 2'b00, 7'b0010000};
    localparam logic [15:0] E_EXI   = {4'b0000, 3'b000, 2'b00, 7'b0001010};
    localparam logic [15:0] E_WBI   = {4'b0100, 3'b000, 2'b00, 7'b0000000};
    localparam logic [15:0] E_MLW   = {4'b0000, 3'b000, 2'b01, 7'b1000000};
    localparam logic [15:0] E_MSW   = {4'b0000, 3'b000, 2'b10, 7'b1000000};
    localparam logic [15:0] E_WBM   = {4'b0100, 3'b000, 2'b00, 7'b0100000};
    localparam logic [15:0] E_BRT   = {4'b0001, 3'b001, 2'b00, 7'b0000011};
    localparam logic [15:0] E_BRN   = {4'b0000, 3'b001, 2'b00, 7'b0000010};
    localparam logic [15:0] E_FLT   = {4'b1000, 3'b000, 2'b00, 7'b0000000};

    typedef struct {
        logic             mr;
        logic             z;
        logic [15:0]      v;
        logic [CNT_W-1:0] ret;
    } exp_t;

    exp_t             sb[$];
    int               n_checks = 0;
    int               n_pass   = 0;
    logic [15:0]      obs_v;
    logic [CNT_W-1:0] obs_ret;

    function automatic logic [15:0] e_exr(input logic [2:0] alu);
        return {4'b0000, alu, 2'b00, 7'b0000010};
    endfunction

    function automatic void want(input logic mr, input logic z, input logic [15:0] v,
                                 input logic [CNT_W-1:0] ret);
        sb.push_back('{mr, z, v, ret});
    endfunction

    task automatic tick(input logic mr, input logic z);
        bus.mem_ready = mr;
        bus.zero      = z;
        @(negedge clk);
        obs_v   = {bus.fault, bus.reg_we, bus.ir_we, bus.pc_we, bus.aluctrl, bus.memctrl, bus.muxctrl};
        obs_ret = bus.retired;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.mem_ready = 1'b0;
        bus.zero = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        exp_t e;
        reset = 1'b1;
        bus.op = OP_LW;
        bus.func = FUNC_ADD;
        want(1'b1, 1'b1, E_ZERO, 0);
        want(1'b1, 1'b1, E_ZERO, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            tick(e.mr, e.z);
            n_checks++;
            if ({obs_v, obs_ret} !== {e.v, e.ret})
                $display("FAIL reset: ctrl=%h retired=%0d, want ctrl=%h retired=%0d", obs_v, obs_ret, e.v, e.ret);
            else n_pass++;
        end
        reset = 1'b0;
        $display("txn reset: outputs=%h retired=%0d", obs_v, obs_ret);
    endtask

    task automatic test_add();
        exp_t e;
        bus.op = OP_RTYPE;
        bus.func = FUNC_ADD;
        want(1'b1, 1'b0, E_FETCH, 0);
        want(1'b1, 1'b0, E_DEC, 0);
        want(1'b1, 1'b0, e_exr(ALU_ADD), 0);
        want(1'b1, 1'b0, E_WBR, 0);
        want(1'b0, 1'b0, E_FWAIT, 1);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            tick(e.mr, e.z);
            n_checks++;
            if ({obs_v, obs_ret} !== {e.v, e.ret})
                $display("FAIL add: ctrl=%h retired=%0d, want ctrl=%h retired=%0d", obs_v, obs_ret, e.v, e.ret);
            else n_pass++;
        end
        $display("txn add: retired=%0d", obs_ret);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        logic [5:0] funcs [4] = '{FUNC_SUB, FUNC_AND, FUNC_OR, FUNC_SLT};
        logic [2:0] alus  [4] = '{ALU_SUB, ALU_AND, ALU_OR, ALU_SLT};
        for (int i = 0; i < 4; i++) begin
            bus.op = OP_RTYPE;
            bus.func = funcs[i];
            want(1'b1, 1'b0, E_FETCH, CNT_W'(i + 1));
            want(1'b1, 1'b0, E_DEC, CNT_W'(i + 1));
            want(1'b1, 1'b0, e_exr(alus[i]), CNT_W'(i + 1));
            want(1'b1, 1'b0, E_WBR, CNT_W'(i + 1));
            while (sb.size() != 0) begin
                e = sb.pop_front();
                tick(e.mr, e.z);
                n_checks++;
                if ({obs_v, obs_ret} !== {e.v, e.ret})
                    $display("FAIL rtype%0d: ctrl=%h retired=%0d, want ctrl=%h retired=%0d", i, obs_v, obs_ret, e.v, e.ret);
                else n_pass++;
            end
            $display("txn rtype func=%b: retired=%0d", funcs[i], obs_ret);
        end
    endtask

    task automatic test_load_store();
        exp_t e;
        do_reset();
        bus.op = OP_LW;
        want(1'b1, 1'b0, E_FETCH, 0);
        want(1'b1, 1'b0, E_DEC, 0);
        want(1'b1, 1'b0, E_EXI, 0);
        for (int i = 0; i < 3; i++) want(1'b0, 1'b0, E_MLW, 0);
        want(1'b1, 1'b0, E_MLW, 0);
        want(1'b1, 1'b0, E_WBM, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            tick(e.mr, e.z);
            n_checks++;
            if ({obs_v, obs_ret} !== {e.v, e.ret})
                $display("FAIL lw: ctrl=%h retired=%0d, want ctrl=%h retired=%0d", obs_v, obs_ret, e.v, e.ret);
            else n_pass++;
        end
        $display("txn lw: retired=%0d", obs_ret);
        bus.op = OP_SW;
        want(1'b1, 1'b0, E_FETCH, 1);
        want(1'b1, 1'b0, E_DEC, 1);
        want(1'b1, 1'b0, E_EXI, 1);
        want(1'b0, 1'b0, E_MSW, 1);
        want(1'b1, 1'b0, E_MSW, 1);
        want(1'b0, 1'b0, E_FWAIT, 2);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            tick(e.mr, e.z);
            n_checks++;
            if ({obs_v, obs_ret} !== {e.v, e.ret})
                $display("FAIL sw: ctrl=%h retired=%0d, want ctrl=%h retired=%0d", obs_v, obs_ret, e.v, e.ret);
            else n_pass++;
        end
        $display("txn sw: retired=%0d", obs_ret);
        bus.op = OP_ADDI;
        want(1'b1, 1'b0, E_FETCH, 2);
        want(1'b1, 1'b0, E_DEC, 2);
        want(1'b1, 1'b0, E_EXI, 2);
        want(1'b1, 1'b0, E_WBI, 2);
        want(1'b1, 1'b0, E_FETCH, 3);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            tick(e.mr, e.z);
            n_checks++;
            if ({obs_v, obs_ret} !== {e.v, e.ret})
                $display("FAIL addi: ctrl=%h retired=%0d, want ctrl=%h retired=%0d", obs_v, obs_ret, e.v, e.ret);
            else n_pass++;
        end
        $display("txn addi: retired=%0d", obs_ret);
    endtask

    task automatic test_mem_timeout();
        exp_t e;
        do_reset();
        bus.op = OP_SW;
        want(1'b1, 1'b0, E_FETCH, 0);
        want(1'b1, 1'b0, E_DEC, 0);
        want(1'b1, 1'b0, E_EXI, 0);
        for (int i = 0; i < 15; i++) want(1'b0, 1'b0, E_MSW, 0);
        want(1'b1, 1'b0, E_FLT, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            tick(e.mr, e.z);
            n_checks++;
            if ({obs_v, obs_ret} !== {e.v, e.ret})
                $display("FAIL mem_timeout: ctrl=%h retired=%0d, want ctrl=%h retired=%0d", obs_v, obs_ret, e.v, e.ret);
            else n_pass++;
        end
        $display("txn sw timeout: fault=%b", obs_v[15]);
        do_reset();
        bus.op = OP_LW;
        want(1'b1, 1'b0, E_FETCH, 0);
        want(1'b1, 1'b0, E_DEC, 0);
        want(1'b1, 1'b0, E_EXI, 0);
        for (int i = 0; i < 14; i++) want(1'b0, 1'b0, E_MLW, 0);
        want(1'b1, 1'b0, E_MLW, 0);
        want(1'b1, 1'b0, E_WBM, 0);
        want(1'b0, 1'b0, E_FWAIT, 1);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            tick(e.mr, e.z);
            n_checks++;
            if ({obs_v, obs_ret} !== {e.v, e.ret})
                $display("FAIL mem_late_ready: ctrl=%h retired=%0d, want ctrl=%h retired=%0d", obs_v, obs_ret, e.v, e.ret);
            else n_pass++;
        end
        $display("txn lw late ready: retired=%0d", obs_ret);
    endtask

    task automatic test_fetch_timeout();
        exp_t e;
        do_reset();
        bus.op = OP_RTYPE;
        bus.func = FUNC_ADD;
        for (int i = 0; i < 15; i++) want(1'b0, 1'b0, E_FWAIT, 0);
        want(1'b0, 1'b0, E_FLT, 0);
        want(1'b1, 1'b0, E_FLT, 0);
        want(1'b1, 1'b1, E_FLT, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            tick(e.mr, e.z);
            n_checks++;
            if ({obs_v, obs_ret} !== {e.v, e.ret})
                $display("FAIL fetch_timeout: ctrl=%h retired=%0d, want ctrl=%h retired=%0d", obs_v, obs_ret, e.v, e.ret);
            else n_pass++;
        end
        $display("txn fetch timeout: fault=%b", obs_v[15]);
        do_reset();
        want(1'b1, 1'b0, E_FETCH, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            tick(e.mr, e.z);
            n_checks++;
            if ({obs_v, obs_ret} !== {e.v, e.ret})
                $display("FAIL fault_clear: ctrl=%h retired=%0d, want ctrl=%h retired=%0d", obs_v, obs_ret, e.v, e.ret);
            else n_pass++;
        end
        $display("txn fault cleared by reset: fault=%b", obs_v[15]);
    endtask

    task automatic test_illegal();
        exp_t e;
        logic [5:0] ops   [2] = '{6'b111111, OP_RTYPE};
        logic [5:0] funcs [2] = '{FUNC_ADD, 6'b100111};
        for (int i = 0; i < 2; i++) begin
            do_reset();
            bus.op = ops[i];
            bus.func = funcs[i];
            want(1'b1, 1'b0, E_FETCH, 0);
            want(1'b1, 1'b0, E_DEC, 0);
            want(1'b1, 1'b0, E_FLT, 0);
            want(1'b0, 1'b0, E_FLT, 0);
            while (sb.size() != 0) begin
                e = sb.pop_front();
                tick(e.mr, e.z);
                n_checks++;
                if ({obs_v, obs_ret} !== {e.v, e.ret})
                    $display("FAIL illegal%0d: ctrl=%h retired=%0d, want ctrl=%h retired=%0d", i, obs_v, obs_ret, e.v, e.ret);
                else n_pass++;
            end
            $display("txn illegal op=%b func=%b: fault=%b", ops[i], funcs[i], obs_v[15]);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        do_reset();
        bus.op = OP_RTYPE;
        bus.func = FUNC_OR;
        want(1'b1, 1'b0, E_FETCH, 0);
        want(1'b1, 1'b0, E_DEC, 0);
        want(1'b1, 1'b0, e_exr(ALU_OR), 0);
        want(1'b1, 1'b0, E_WBR, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            tick(e.mr, e.z);
            n_checks++;
            if ({obs_v, obs_ret} !== {e.v, e.ret})
                $display("FAIL pre_reset_or: ctrl=%h retired=%0d, want ctrl=%h retired=%0d", obs_v, obs_ret, e.v, e.ret);
            else n_pass++;
        end
        bus.op = OP_LW;
        want(1'b1, 1'b0, E_FETCH, 1);
        want(1'b1, 1'b0, E_DEC, 1);
        want(1'b1, 1'b0, E_EXI, 1);
        want(1'b0, 1'b0, E_MLW, 1);
        want(1'b0, 1'b0, E_MLW, 1);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            tick(e.mr, e.z);
            n_checks++;
            if ({obs_v, obs_ret} !== {e.v, e.ret})
                $display("FAIL mid_lw: ctrl=%h retired=%0d, want ctrl=%h retired=%0d", obs_v, obs_ret, e.v, e.ret);
            else n_pass++;
        end
        reset = 1'b1;
        want(1'b1, 1'b0, E_ZERO, 0);
        want(1'b1, 1'b0, E_ZERO, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            tick(e.mr, e.z);
            n_checks++;
            if ({obs_v, obs_ret} !== {e.v, e.ret})
                $display("FAIL mid_reset: ctrl=%h retired=%0d, want ctrl=%h retired=%0d", obs_v, obs_ret, e.v, e.ret);
            else n_pass++;
        end
        reset = 1'b0;
        want(1'b1, 1'b0, E_FETCH, 0);
        want(1'b1, 1'b0, E_DEC, 0);
        while (sb.size() != 0) begin
            e = sb.pop_front();
            tick(e.mr, e.z);
            n_checks++;
            if ({obs_v, obs_ret} !== {e.v, e.ret})
                $display("FAIL post_reset: ctrl=%h retired=%0d, want ctrl=%h retired=%0d", obs_v, obs_ret, e.v, e.ret);
            else n_pass++;
        end
        $display("txn lw aborted by reset: retired=%0d", obs_ret);
    endtask

    task automatic test_branch();
        exp_t e;
`ifdef CTRL_BRANCH_EN
        logic [5:0]  ops   [4] = '{OP_BEQ, OP_BEQ, OP_BNE, OP_BNE};
        logic        zeros [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [15:0] exps  [4] = '{E_BRT, E_BRN, E_BRT, E_BRN};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.op = ops[i];
            want(1'b1, 1'b0, E_FETCH, CNT_W'(i));
            want(1'b1, 1'b0, E_DEC, CNT_W'(i));
            want(1'b1, zeros[i], exps[i], CNT_W'(i));
            while (sb.size() != 0) begin
                e = sb.pop_front();
                tick(e.mr, e.z);
                n_checks++;
                if ({obs_v, obs_ret} !== {e.v, e.ret})
                    $display("FAIL branch%0d: ctrl=%h retired=%0d, want ctrl=%h retired=%0d", i, obs_v, obs_ret, e.v, e.ret);
                else n_pass++;
            end
            $display("txn branch op=%b zero=%b: pc_we=%b", ops[i], zeros[i], obs_v[12]);
        end
        want(1'b0, 1'b0, E_FWAIT, 4);
`else
        do_reset();
        bus.op = OP_BEQ;
        want(1'b1, 1'b0, E_FETCH, 0);
        want(1'b1, 1'b0, E_DEC, 0);
        want(1'b1, 1'b1, E_FLT, 0);
`endif
        while (sb.size() != 0) begin
            e = sb.pop_front();
            tick(e.mr, e.z);
            n_checks++;
            if ({obs_v, obs_ret} !== {e.v, e.ret})
                $display("FAIL branch_end: ctrl=%h retired=%0d, want ctrl=%h retired=%0d", obs_v, obs_ret, e.v, e.ret);
            else n_pass++;
        end
        $display("txn branch final: ctrl=%h retired=%0d", obs_v, obs_ret);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks done=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.op = '0;
        bus.func = '0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        test_reset();
        test_add();
        test_back_to_back();
        test_load_store();
        test_mem_timeout();
        test_fetch_timeout();
        test_illegal();
        test_reset_mid();
        test_branch();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
